t03_mem_req_arbiter: RTL and testbench

- Sits directly upstream of the MMIO interface and is the only master on its read/write/address/data/dataOut/ack port.
- Merges the instruction-fetch port and the load/store (data) port into single, non-overlapping MMIO transactions.
- Holds each request stable until ack, returns read data to the winning requester and pulses that requester's done strobe.
- A watchdog aborts transactions the MMIO side never acknowledges.

---
 rtl/t03_mem_req_arbiter.sv | 165 ++++++++++++++++
 tb/tb_t03_mem_req_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/t03_mem_req_arbiter.sv
// Merges the instruction-fetch and load/store ports into single MMIO transactions with a watchdog.
// Optional T03_ARB_ROUND_ROBIN_EN: contended grants alternate instead of data-over-instruction priority.
module t03_mem_req_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              err,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] dataOut,
  input  logic              ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_IREQ = 2'd1;
  localparam logic [1:0] S_DREQ = 2'd2;

  // Counter only needs to reach TIMEOUT_CYCLES-1; the abort fires on the cycle it would hit TIMEOUT_CYCLES.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              err_q, err_d;
  logic              d_req;
  logic              pick_d;

  assign d_req = d_read | d_write;

`ifdef T03_ARB_ROUND_ROBIN_EN
  // last_d_q = 1 when the most recent grant went to the data port.
  logic last_d_q, last_d_d;

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == S_IDLE) begin
      if (pick_d)      last_d_d = 1'b1;
      else if (i_read) last_d_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_d_q <= 1'b0;
    else      last_d_q <= last_d_d;
  end

  assign pick_d = d_req & (~i_read | ~last_d_q);
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_d) begin
          state_d = S_DREQ;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          we_d    = d_write;
          cnt_d   = '0;
        end else if (i_read) begin
          state_d = S_IREQ;
          addr_d  = i_addr;
          we_d    = 1'b0;
          cnt_d   = '0;
        end
      end
      S_IREQ, S_DREQ: begin
        if (ack) begin
          state_d = S_IDLE;
          if (state_q == S_IREQ) begin
            i_ack_d   = 1'b1;
            i_rdata_d = dataOut;
          end else begin
            d_ack_d = 1'b1;
            if (!we_q) d_rdata_d = dataOut;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          if (state_q == S_IREQ) begin
            i_ack_d   = 1'b1;
            i_rdata_d = '0;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      err_q     <= err_d;
    end
  end

  // Strobes decode from state so they drop the instant reset asserts.
  assign read    = (state_q == S_IREQ) | ((state_q == S_DREQ) & ~we_q);
  assign write   = (state_q == S_DREQ) & we_q;
  assign address = addr_q;
  assign data    = wdata_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign err     = err_q;

endmodule

// File: tb/tb_t03_mem_req_arbiter.sv
// Directed bench for t03_mem_req_arbiter: fetch, store/load, contention, watchdog, reset abort.
module tb_t03_mem_req_arbiter;
  logic        clk, rst;
  logic        i_read, d_read, d_write, ack;
  logic [31:0] i_addr, d_addr, d_wdata, dataOut;
  logic [31:0] i_rdata, d_rdata, address, data;
  logic        i_ack, d_ack, err, read, write;
  int          pass_cnt, fail_cnt, total;

  t03_mem_req_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
    .read(read), .write(write), .address(address), .data(data),
    .dataOut(dataOut), .ack(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    pass_cnt = 0; fail_cnt = 0; total = 0;
    rst = 1'b0; i_read = 0; d_read = 0; d_write = 0; ack = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; dataOut = 0;
    #3;
    chk("rst_read", read, 0); chk("rst_write", write, 0); chk("rst_addr", address, 0);
    chk("rst_iack", i_ack, 0); chk("rst_dack", d_ack, 0); chk("rst_err", err, 0);
    tick();
    rst = 1'b1;

    // Fetch, MMIO acks in its second cycle
    i_read = 1; i_addr = 32'h0;
    tick();
    chk("f_read1", read, 1); chk("f_write1", write, 0); chk("f_addr1", address, 0);
    i_read = 0;
    tick();
    chk("f_read2", read, 1); chk("f_addr2", address, 0);
    ack = 1; dataOut = 32'h003100B3;
    tick();
    ack = 0;
    chk("f_iack", i_ack, 1); chk("f_rdata", i_rdata, 32'h003100B3);
    chk("f_dack", d_ack, 0); chk("f_err", err, 0); chk("f_read_off", read, 0);
    tick();
    chk("f_iack_pulse", i_ack, 0); chk("f_rdata_hold", i_rdata, 32'h003100B3);

    // Store then load
    d_write = 1; d_addr = 32'h8; d_wdata = 32'hDEADBEEF;
    tick();
    d_write = 0;
    chk("s_write", write, 1); chk("s_read", read, 0);
    chk("s_data", data, 32'hDEADBEEF); chk("s_addr", address, 32'h8);
    ack = 1; dataOut = 32'h12345678;
    tick();
    ack = 0;
    chk("s_dack", d_ack, 1); chk("s_write_off", write, 0); chk("s_rdata_keep", d_rdata, 0);
    d_read = 1; d_addr = 32'h8;
    chk("l_gap", read, 0);
    tick();
    d_read = 0;
    chk("l_read", read, 1); chk("l_addr", address, 32'h8);
    ack = 1; dataOut = 32'hDEADBEEF;
    tick();
    ack = 0;
    chk("l_dack", d_ack, 1); chk("l_rdata", d_rdata, 32'hDEADBEEF);

    // Watchdog: read held 4 cycles, then d_ack with err
    d_read = 1; d_addr = 32'h40;
    tick();
    d_read = 0;
    chk("t_read1", read, 1);
    tick(); chk("t_read2", read, 1);
    tick(); chk("t_read3", read, 1);
    tick(); chk("t_read4", read, 1);
    tick();
    chk("t_read_off", read, 0); chk("t_dack", d_ack, 1); chk("t_err", err, 1);
    chk("t_rdata", d_rdata, 0);
    ack = 1; dataOut = 32'h55;
    tick();
    ack = 0;
    chk("t_late_dack", d_ack, 0); chk("t_late_err", err, 0); chk("t_late_rdata", d_rdata, 0);
    chk("t_late_read", read, 0);

    // Boundary: ack in the fourth request cycle wins over the timeout
    d_read = 1; d_addr = 32'h44;
    tick();
    d_read = 0;
    tick(); tick(); tick();
    chk("b_read4", read, 1);
    ack = 1; dataOut = 32'hCAFEF00D;
    tick();
    ack = 0;
    chk("b_dack", d_ack, 1); chk("b_err", err, 0); chk("b_rdata", d_rdata, 32'hCAFEF00D);
    tick();

    // Contention, starting from a fresh last-grant flag
    rst = 0; #1;
    chk("r2_drdata", d_rdata, 0); chk("r2_irdata", i_rdata, 0);
    rst = 1;
    i_read = 1; i_addr = 32'h100; d_read = 1; d_addr = 32'h200;
    tick();
    chk("c1_addr", address, 32'h200); chk("c1_read", read, 1);
    ack = 1; dataOut = 32'hA;
    tick();
    ack = 0;
    chk("c1_dack", d_ack, 1); chk("c1_iack", i_ack, 0); chk("c1_rdata", d_rdata, 32'hA);
    chk("c1_gap", read, 0);
    tick();
`ifdef T03_ARB_ROUND_ROBIN_EN
    chk("c2_addr", address, 32'h100);
    i_read = 0;
`else
    chk("c2_addr", address, 32'h200);
    d_read = 0;
`endif
    ack = 1; dataOut = 32'hB;
    tick();
    ack = 0;
`ifdef T03_ARB_ROUND_ROBIN_EN
    chk("c2_iack", i_ack, 1); chk("c2_rdata", i_rdata, 32'hB);
`else
    chk("c2_dack", d_ack, 1); chk("c2_rdata", d_rdata, 32'hB);
`endif
    tick();
`ifdef T03_ARB_ROUND_ROBIN_EN
    chk("c3_addr", address, 32'h200);
`else
    chk("c3_addr", address, 32'h100);
`endif
    i_read = 0; d_read = 0;
    ack = 1; dataOut = 32'hC;
    tick();
    ack = 0;
`ifdef T03_ARB_ROUND_ROBIN_EN
    chk("c3_dack", d_ack, 1); chk("c3_rdata", d_rdata, 32'hC);
`else
    chk("c3_iack", i_ack, 1); chk("c3_rdata", i_rdata, 32'hC);
`endif
    tick();

    // Reset during a store: outputs clear without a clock edge
    d_write = 1; d_addr = 32'h300; d_wdata = 32'h77;
    tick();
    d_write = 0;
    chk("m_write", write, 1);
    #2 rst = 0;
    #1;
    chk("m_write_rst", write, 0); chk("m_read_rst", read, 0);
    chk("m_addr_rst", address, 0); chk("m_data_rst", data, 0); chk("m_dack_rst", d_ack, 0);
    ack = 1; dataOut = 32'h66;
    #1 rst = 1;
    tick();
    ack = 0;
    chk("m_late_dack", d_ack, 0); chk("m_late_rdata", d_rdata, 0);
    i_read = 1; i_addr = 32'h4;
    tick();
    i_read = 0;
    chk("m_f_read", read, 1); chk("m_f_addr", address, 32'h4);
    ack = 1; dataOut = 32'h99;
    tick();
    ack = 0;
    chk("m_f_iack", i_ack, 1); chk("m_f_rdata", i_rdata, 32'h99); chk("m_f_err", err, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
